gpr_bank: RTL

Parametrised general-purpose register bank for the core_lapido datapath, sitting between decode (read ports, scoreboard issue) and writeback (write port). It generalises the earlier 16×32 bank with configurable width and depth, and adds four behaviours:
- half-word write modes for lcl/lch
- write-to-read bypass
- a per-register pending-write scoreboard with stall outputs
- a multi-cycle synchronous clear sequencer

---
 rtl/gpr_bank_pkg.sv | 21 ++
 rtl/gpr_bank_if.sv | 36 +++
 rtl/gpr_bank_write_merge.sv | 27 ++
 rtl/gpr_bank.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gpr_bank_pkg.sv
// Shared definitions for the gpr_bank register file: default sizes,
// write-mode encodings and clear-sequencer state encodings.
package gpr_bank_pkg;

  localparam int GPR_WIDTH          = 32;
  localparam int REGISTER_FILE_SIZE = 16;
  localparam int GPR_AW             = 5;

  typedef enum logic [1:0] {
    WM_WORD = 2'b00,
    WM_LOW  = 2'b01,
    WM_HIGH = 2'b10,
    WM_NONE = 2'b11
  } wr_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/gpr_bank_if.sv
// Decode/writeback bus of the register bank: write port, two read ports,
// scoreboard issue/stall and the clear handshake.
interface gpr_bank_if
  import gpr_bank_pkg::*;
#(
  parameter int WIDTH = GPR_WIDTH,
  parameter int AW    = GPR_AW
) ();

  logic             wr_en;
  wr_mode_e         wr_mode;
  logic [AW-1:0]    rd;
  logic [WIDTH-1:0] data;
  logic [AW-1:0]    rs;
  logic [AW-1:0]    rt;
  logic [WIDTH-1:0] data_rs;
  logic [WIDTH-1:0] data_rt;
  logic             issue_en;
  logic [AW-1:0]    issue_rd;
  logic             stall_rs;
  logic             stall_rt;
  logic             clr_req;
  logic             clr_busy;
  logic             clr_done;

  modport master (
    output wr_en, wr_mode, rd, data, rs, rt, issue_en, issue_rd, clr_req,
    input  data_rs, data_rt, stall_rs, stall_rt, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_mode, rd, data, rs, rt, issue_en, issue_rd, clr_req,
    output data_rs, data_rt, stall_rs, stall_rt, clr_busy, clr_done
  );

endinterface

// File: rtl/gpr_bank_write_merge.sv
// Combinational write merge: produces the post-write register value for
// word, low-half (lcl) and high-half (lch) writes.
module gpr_write_merge
  import gpr_bank_pkg::*;
#(
  parameter int WIDTH = GPR_WIDTH
) (
  input  logic [WIDTH-1:0] old_val,
  input  logic [WIDTH-1:0] data,
  input  wr_mode_e         mode,
  output logic [WIDTH-1:0] new_val
);

  localparam int H = WIDTH / 2;

  // Half-word modes always take their payload from the low half of data.
  always_comb begin
    new_val = old_val;
    case (mode)
      WM_WORD: new_val = data;
      WM_LOW:  new_val = {old_val[WIDTH-1:H], data[H-1:0]};
      WM_HIGH: new_val = {data[H-1:0], old_val[H-1:0]};
      default: new_val = old_val;
    endcase
  end

endmodule

// File: rtl/gpr_bank.sv
// Parametrised general-purpose register bank with half-word writes,
// write-to-read bypass, pending-write scoreboard and a clear sequencer.
module gpr_bank
  import gpr_bank_pkg::*;
#(
  parameter int WIDTH    = GPR_WIDTH,
  parameter int DEPTH    = REGISTER_FILE_SIZE,
  parameter int AW       = GPR_AW,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input logic       clk,
  input logic       rst_n,
  gpr_bank_if.slave bus
);

  localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  clr_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic             idle_s, wr_ok_s, issue_ok_s;
  logic             rs_ok_s, rt_ok_s, byp_rs_s, byp_rt_s;
  logic             pend_rs_s, pend_rt_s;
  logic             clr_busy_s, clr_done_s;
  logic [WIDTH-1:0] old_rd_s, old_rs_s, old_rt_s;
  logic [WIDTH-1:0] new_rd_s, new_rs_s, new_rt_s;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  // Qualify the write, issue and read ports against range, zero register and clear state.
  always_comb begin
    idle_s     = (state_q == ST_IDLE);
    wr_ok_s    = bus.wr_en && (bus.wr_mode != WM_NONE) && idle_s && addr_ok(bus.rd);
    issue_ok_s = bus.issue_en && idle_s && addr_ok(bus.issue_rd);
    rs_ok_s    = addr_ok(bus.rs);
    rt_ok_s    = addr_ok(bus.rt);
    byp_rs_s   = BYPASS && wr_ok_s && (bus.rd == bus.rs);
    byp_rt_s   = BYPASS && wr_ok_s && (bus.rd == bus.rt);
  end

  // Address-match lookup; an address matching no register yields zero.
  always_comb begin
    old_rd_s  = '0;
    old_rs_s  = '0;
    old_rt_s  = '0;
    pend_rs_s = 1'b0;
    pend_rt_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      old_rd_s  = old_rd_s | ({WIDTH{bus.rd == AW'(i)}} & regs_q[i]);
      old_rs_s  = old_rs_s | ({WIDTH{bus.rs == AW'(i)}} & regs_q[i]);
      old_rt_s  = old_rt_s | ({WIDTH{bus.rt == AW'(i)}} & regs_q[i]);
      pend_rs_s = pend_rs_s | ((bus.rs == AW'(i)) && pend_q[i]);
      pend_rt_s = pend_rt_s | ((bus.rt == AW'(i)) && pend_q[i]);
    end
  end

  gpr_write_merge #(.WIDTH(WIDTH)) u_merge_wr (
    .old_val (old_rd_s),
    .data    (bus.data),
    .mode    (bus.wr_mode),
    .new_val (new_rd_s)
  );

  gpr_write_merge #(.WIDTH(WIDTH)) u_merge_rs (
    .old_val (old_rs_s),
    .data    (bus.data),
    .mode    (bus.wr_mode),
    .new_val (new_rs_s)
  );

  gpr_write_merge #(.WIDTH(WIDTH)) u_merge_rt (
    .old_val (old_rt_s),
    .data    (bus.data),
    .mode    (bus.wr_mode),
    .new_val (new_rt_s)
  );

  assign bus.data_rs  = rs_ok_s ? (byp_rs_s ? new_rs_s : old_rs_s) : '0;
  assign bus.data_rt  = rt_ok_s ? (byp_rt_s ? new_rt_s : old_rt_s) : '0;
  assign bus.stall_rs = idle_s && rs_ok_s && pend_rs_s && !byp_rs_s;
  assign bus.stall_rt = idle_s && rt_ok_s && pend_rt_s && !byp_rt_s;
  assign bus.clr_busy = clr_busy_s;
  assign bus.clr_done = clr_done_s;

  // Next register and scoreboard contents: clear one entry per cycle, else write/issue.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    case (state_q)
      ST_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) begin
          regs_d[i] = (idx_q == IW'(i)) ? '0   : regs_q[i];
          pend_d[i] = (idx_q == IW'(i)) ? 1'b0 : pend_q[i];
        end
      end
      ST_IDLE: begin
        for (int i = 0; i < DEPTH; i++) begin
          regs_d[i] = (wr_ok_s && (bus.rd == AW'(i))) ? new_rd_s : regs_q[i];
          // A newly issued producer outranks a same-cycle writeback to the same register.
          pend_d[i] = (issue_ok_s && (bus.issue_rd == AW'(i))) ? 1'b1 :
                      (wr_ok_s && (bus.rd == AW'(i)))          ? 1'b0 : pend_q[i];
        end
      end
      default: begin
        regs_d = regs_q;
        pend_d = pend_q;
      end
    endcase
  end

  // Register array and scoreboard storage; reset also completes an interrupted clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Clear sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Clear sequencer next state; requests arriving mid-clear are dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
        idx_d = '0;
      end
      ST_CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          state_d = ST_CLEAR;
          idx_d   = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Clear sequencer outputs.
  always_comb begin
    clr_busy_s = 1'b0;
    clr_done_s = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_busy_s = 1'b1;
        clr_done_s = (idx_q == LAST_IDX);
      end
      default: begin
        clr_busy_s = 1'b0;
        clr_done_s = 1'b0;
      end
    endcase
  end

endmodule
